pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
// - IF-stage program counter and instruction fetch sequencer; consumer of the branch target produced by incrementor_PC_immediate.
// - Holds the PC and issues req/ack fetches to instruction memory.
// - Drives the IF/ID instruction register; handles decode stalls and taken-branch redirects with a one-cycle bubble.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded on Reset
// - PC_STEP   32'd4          sequential PC increment
// PORTS
// - Clk            in   1   rising-edge clock
// - Reset          in   1   asynchronous, active-high reset
// - PC_LdEn        in   1   1 = decode consumes Instr this cycle; 0 = stall
// - Branch_Taken   in   1   redirect request, valid this cycle
// - Branch_Target  in   32  redirect address (incrementor_PC_immediate Out); bits [1:0] ignored
// - Mem_Ack        in   1   instruction memory: Mem_Instr valid for Mem_Addr
// - Mem_Instr      in   32  fetched instruction word
// - Mem_Req        out  1   fetch request, registered
// - Mem_Addr       out  32  fetch address, equals PC
// - PC             out  32  current fetch PC, [1:0] always 00
// - PC_plus4       out  32  PC+PC_STEP, combinational; feeds incrementor In1
// - Instr          out  32  IF/ID instruction register
// - Instr_Valid    out  1   Instr holds an unconsumed instruction
// BEHAVIOUR
// - Reset (async, no clock needed):
//   - PC=RESET_PC, Mem_Req=0, Instr=0, Instr_Valid=0, state=IDLE.
// - States:
//   - IDLE: one cycle after Reset release -> REQ.
//   - REQ: Mem_Req=1.
//   - HOLD: Mem_Req=0.
//   - REDIRECT: Mem_Req=0, one cycle -> REQ.
// - accept = Mem_Ack & ~Branch_Taken & (~Instr_Valid | PC_LdEn), evaluated in REQ only.
// - REQ, per cycle, priority order:
//   1. Branch_Taken: PC<=Branch_Target&~3, Instr_Valid<=0, -> REDIRECT. Any same-cycle ack is dropped.
//   2. Instr_Valid & ~PC_LdEn: -> HOLD; PC unchanged; ack dropped (refetched later).
//   3. accept: Instr<=Mem_Instr, Instr_Valid<=1, PC<=PC+PC_STEP, stay REQ.
//   4. Otherwise: Instr_Valid<=Instr_Valid & ~PC_LdEn, stay REQ.
// - HOLD:
//   - Branch_Taken: PC<=target, Instr_Valid<=0, -> REDIRECT.
//   - Else if PC_LdEn: Instr_Valid<=0, -> REQ.
//   - Else: all outputs frozen.
// - Branch_Taken has priority over stall in every state. In IDLE/REDIRECT it loads PC and enters/stays REDIRECT.
// - Mem_Addr is stable while Mem_Req=1 until ack or withdrawal. Memory must tolerate withdrawn requests (read-only, no side effects).
// - Latency: ack in cycle n -> Instr/Instr_Valid visible cycle n+1. Back-to-back acks give one instruction per cycle.
// - Arithmetic: PC+PC_STEP is modulo 2^32 (0xFFFFFFFC -> 0x00000000); no overflow flag.
// - Instr is not cleared when Instr_Valid drops; only Reset clears it.
// TESTING
// 1. Reset=1 mid-run (no clock edge) -> PC=0, Mem_Req=0, Instr_Valid=0 immediately. Release -> 1 cycle IDLE, then Mem_Req=1, Mem_Addr=0.
// 2. Mem_Ack=1 every cycle, PC_LdEn=1, Mem_Instr=0x2008_0005,0x2009_0003,.. -> Mem_Addr 0,4,8; Instr follows one cycle later; Instr_Valid stays 1.
// 3. Instr_Valid=1, PC_LdEn=0 for 3 cycles -> HOLD; Instr, PC frozen; Mem_Req=0. PC_LdEn=1 -> REQ, same PC refetched.
// 4. Branch_Taken=1 with Branch_Target=0x0000_0043 and Mem_Ack=1 same cycle -> instruction dropped, Instr_Valid=0, one bubble, then Mem_Addr=0x40.
// 5. Branch to 0xFFFF_FFFC, ack -> PC=0x0000_0000, PC_plus4=0x0000_0004.
// 6. Branch_Taken during HOLD with PC_LdEn=0 -> REDIRECT, Instr_Valid=0, next fetch at target.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF-stage PC register and req/ack instruction fetch sequencer
// Feeds the IF/ID instruction register; branches redirect with a one-cycle bubble.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PC_LdEn,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Instr,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [31:0] Instr,
  output logic        Instr_Valid
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_HOLD     = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        mem_req_q;
  logic [31:0] target_aligned;
  logic        accept;

  assign target_aligned = Branch_Target & ~32'd3;
  assign accept         = Mem_Ack & ~Branch_Taken & (~valid_q | PC_LdEn);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      valid_q   <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      mem_req_q <= (state_d == S_REQ);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    // A taken branch outranks stalls and acks in every state.
    if (Branch_Taken) begin
      pc_d    = target_aligned;
      valid_d = 1'b0;
      state_d = S_REDIRECT;
    end else begin
      unique case (state_q)
        S_IDLE:     state_d = S_REQ;
        S_REDIRECT: state_d = S_REQ;
        S_REQ: begin
          if (valid_q && !PC_LdEn) begin
            // Decode is full: drop any ack, this PC is refetched after the stall.
            state_d = S_HOLD;
          end else if (accept) begin
            instr_d = Mem_Instr;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_STEP;
          end else begin
            valid_d = valid_q & ~PC_LdEn;
          end
        end
        S_HOLD: begin
          if (PC_LdEn) begin
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign Mem_Req     = mem_req_q;
  assign Mem_Addr    = pc_q;
  assign PC          = pc_q;
  assign PC_plus4    = pc_q + PC_STEP;
  assign Instr       = instr_q;
  assign Instr_Valid = valid_q;

endmodule
